fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 78 +++++++
 tb/tb_fetch_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage with program counter and IF/ID pipeline register.
// Optional build macro: FETCH_DELAY_SLOT_EN (branch-delay-slot semantics on redirect).
module fetch_stage #(
    parameter logic [31:0] PC_RESET     = 32'h0040_0000,
    parameter logic [31:0] PC_INCREMENT = 32'h0000_0004,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_target_in,
    output logic [31:0] imem_addr_out,
    input  logic [31:0] imem_data_in,
    output logic [31:0] id_instr_out,
    output logic [31:0] id_pc_out,
    output logic [31:0] id_pc_plus4_out,
    output logic        id_valid_out
);

    logic [31:0] pc;
    logic [31:0] nextPc;
    logic        ifValid;
    logic        keepSlot;

    // The ROM is synchronous, so the address must be the PC we will hold next cycle.
    always_comb begin
        nextPc = pc + PC_INCREMENT;
        if (reset) begin
            nextPc = PC_RESET;
        end else if (redirect_in) begin
            nextPc = {redirect_target_in[31:2], 2'b00};
        end else if (stall_in || !ifValid) begin
            nextPc = pc;
        end
    end

    assign imem_addr_out = nextPc;

`ifdef FETCH_DELAY_SLOT_EN
    // The word already fetched at pc is the delay slot and must still reach decode.
    assign keepSlot = ifValid;
`else
    assign keepSlot = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            pc              <= PC_RESET;
            ifValid         <= 1'b0;
            id_instr_out    <= NOP_INSTR;
            id_pc_out       <= PC_RESET;
            id_pc_plus4_out <= PC_RESET + PC_INCREMENT;
            id_valid_out    <= 1'b0;
        end else begin
            pc      <= nextPc;
            ifValid <= 1'b1;
            if (redirect_in && !keepSlot) begin
                id_instr_out <= NOP_INSTR;
                id_valid_out <= 1'b0;
            end else if (stall_in && !redirect_in) begin
                id_instr_out    <= id_instr_out;
                id_pc_out       <= id_pc_out;
                id_pc_plus4_out <= id_pc_plus4_out;
                id_valid_out    <= id_valid_out;
            end else if (!ifValid) begin
                id_instr_out <= NOP_INSTR;
                id_valid_out <= 1'b0;
            end else begin
                id_instr_out    <= imem_data_in;
                id_pc_out       <= pc;
                id_pc_plus4_out <= pc + PC_INCREMENT;
                id_valid_out    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage: directed plan then randomized stall/redirect/reset.
module tb_fetch_stage;

    localparam logic [31:0] PC_RESET = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_target_in;
    logic [31:0] imem_addr_out;
    logic [31:0] imem_data_in;
    logic [31:0] id_instr_out;
    logic [31:0] id_pc_out;
    logic [31:0] id_pc_plus4_out;
    logic        id_valid_out;

    fetch_stage dut (
        .clock              (clock),
        .reset              (reset),
        .stall_in           (stall_in),
        .redirect_in        (redirect_in),
        .redirect_target_in (redirect_target_in),
        .imem_addr_out      (imem_addr_out),
        .imem_data_in       (imem_data_in),
        .id_instr_out       (id_instr_out),
        .id_pc_out          (id_pc_out),
        .id_pc_plus4_out    (id_pc_plus4_out),
        .id_valid_out       (id_valid_out)
    );

    always #5 clock = ~clock;

    // Synchronous instruction ROM: word content is the address XOR a per-phase key.
    logic [31:0] romXor = 32'h0;
    always @(posedge clock) imem_data_in <= imem_addr_out ^ romXor;

    int passed = 0;
    int total  = 0;

    // Reference model: the address the ROM is presenting, whether it is real, and what decode holds.
    logic [31:0] romAddr;
    logic        romLive;
    logic [31:0] decInstr, decPc, decPc4;
    logic        decValid;
    logic        modelKnown = 1'b0;
    logic [31:0] lastAddr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkDecode();
        check("id_valid", {31'b0, id_valid_out}, {31'b0, decValid});
        check("id_instr", id_instr_out, decInstr);
        check("id_pc", id_pc_out, decPc);
        check("id_pc_plus4", id_pc_plus4_out, decPc4);
    endtask

    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
        logic [31:0] want;
        logic        delivered;
        logic        squashed;
        @(negedge clock);
        reset = r; stall_in = s; redirect_in = d; redirect_target_in = t;
        #1;
        if (r) want = PC_RESET;
        else if (d) want = t & 32'hFFFF_FFFC;
        else if (s || !romLive) want = romAddr;
        else want = romAddr + 32'd4;
        lastAddr = imem_addr_out;
        if (modelKnown || r) check("imem_addr", imem_addr_out, want);
        if (modelKnown) checkDecode();
        @(posedge clock);
        if (r) begin
            decInstr = 32'h0; decPc = PC_RESET; decPc4 = PC_RESET + 32'd4; decValid = 1'b0;
        end else begin
`ifdef FETCH_DELAY_SLOT_EN
            delivered = romLive && (d || !s);
            squashed  = !delivered && (d || !romLive);
`else
            delivered = romLive && !d && !s;
            squashed  = d || (!s && !romLive);
`endif
            if (delivered) begin
                decInstr = romAddr ^ romXor; decPc = romAddr; decPc4 = romAddr + 32'd4; decValid = 1'b1;
            end else if (squashed) begin
                decInstr = 32'h0; decValid = 1'b0;
            end
        end
        romAddr    = want;
        romLive    = !r;
        modelKnown = 1'b1;
    endtask

    task automatic expectId(input logic [31:0] pc);
        #1;
        check("plan_valid", {31'b0, id_valid_out}, 32'd1);
        check("plan_pc", id_pc_out, pc);
        check("plan_instr", id_instr_out, pc);
    endtask

    task automatic expectBubble();
        #1;
        check("plan_bubble", {31'b0, id_valid_out}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; stall_in = 1'b0; redirect_in = 1'b0; redirect_target_in = 32'h0;

        repeat (3) step(1, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        check("warmup_addr", lastAddr, 32'h0040_0000);
        expectBubble();
        step(0, 0, 0, 32'h0); expectId(32'h0040_0000);
        step(0, 0, 0, 32'h0); expectId(32'h0040_0004);
        step(0, 0, 0, 32'h0); expectId(32'h0040_0008);

        repeat (4) begin
            step(0, 1, 0, 32'h0);
            check("stall_addr", lastAddr, 32'h0040_000C);
            expectId(32'h0040_0008);
        end
        step(0, 0, 0, 32'h0); expectId(32'h0040_000C);

        step(0, 0, 1, 32'h0040_0100);
`ifdef FETCH_DELAY_SLOT_EN
        expectId(32'h0040_0010);
`else
        expectBubble();
`endif
        step(0, 0, 0, 32'h0); expectId(32'h0040_0100);

        step(0, 1, 1, 32'h0040_0203);
        check("redir_stall_addr", lastAddr, 32'h0040_0200);
        step(0, 0, 0, 32'h0); expectId(32'h0040_0200);

        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 32'h0);
        check("wrap_addr", lastAddr, 32'h0000_0000);
        expectId(32'hFFFF_FFFC);
        check("wrap_plus4", id_pc_plus4_out, 32'h0000_0000);
        step(0, 0, 0, 32'h0); expectId(32'h0000_0000);

        step(0, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        #1;
        check("rst_valid", {31'b0, id_valid_out}, 32'd0);
        check("rst_instr", id_instr_out, 32'h0);
        check("rst_pc", id_pc_out, PC_RESET);
        step(0, 0, 0, 32'h0); expectBubble();
        step(0, 0, 0, 32'h0); expectId(32'h0040_0000);

        romXor = 32'h1357_9BDF;
        step(1, 0, 0, 32'h0);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, tgt);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
